xcorr_engine: RTL
=================

Name: xcorr_engine

Overview:
- Parametrised full cross-correlation engine: r[n] = sum_k a[n-k]*b[LEN-1-k], for n = 0..2*LEN-2.
- Successor to the fixed 10-bit/2000-sample correlator. Adds sample-RAM read ports instead of array ports, a signed mode, a lag window, a per-lag result stream, a start/done handshake and restart.
- Sits between the two capture sample RAMs and the top-level controller, which consumes max_val/max_idx.

Parameters:
- DATA_W, 10, sample width.
- LEN, 2000, samples per signal.
- SIGNED, 0; 1 treats samples and results as two's complement.
- ADDR_W, $clog2(LEN), sample RAM address width.
- IDX_W, $clog2(2*LEN-1), lag index width.
- ACC_W, 2*DATA_W+$clog2(LEN), accumulator/result width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- lag_lo  in  IDX_W  first lag to compute; sampled on accepted start.
- lag_hi  in  IDX_W  last lag to compute; sampled on accepted start.
- a_addr  out  ADDR_W  RAM A read address.
- b_addr  out  ADDR_W  RAM B read address.
- a_data  in  DATA_W  RAM A data; 1-cycle registered read latency.
- b_data  in  DATA_W  RAM B data; 1-cycle registered read latency.
- res_valid  out  1  one-cycle strobe per completed lag; no backpressure.
- res_idx  out  IDX_W  lag of the current res_data.
- res_data  out  ACC_W  r[res_idx].
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- err  out  1  window invalid on the last start.
- max_val  out  ACC_W  largest r over the window.
- max_idx  out  IDX_W  lag of max_val.

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE. All outputs 0, including addresses and max_val/max_idx. Reset mid-run aborts with no further res_valid.
- States:
  - IDLE: on start, go to RUN (or to DONE if the window is invalid).
  - RUN: issue addresses; go to DRAIN after the last address of lag_hi.
  - DRAIN: wait 3 cycles for the pipeline to empty, then go to DONE.
  - DONE: hold results; on start, behave as IDLE. start is ignored in RUN/DRAIN.
- Window check on start:
  - lag_hi > 2*LEN-2 is clamped to 2*LEN-2.
  - If lag_lo > clamped lag_hi: next cycle DONE, err=1, no res_valid, max_val/max_idx=0.
  - Otherwise err=0.
- Addressing: for lag n, k runs ascending over max(0,n-LEN+1)..min(n,LEN-1). Only overlapping terms are issued, no zero padding. a_addr=n-k, b_addr=LEN-1-k.
- Throughput: one address pair per cycle, with no bubble between lags. RUN lasts exactly the sum of the overlaps in the window.
- Pipeline:
  - Cycle t: address issued.
  - t+1: RAM data valid.
  - t+2: product registered (2*DATA_W, signedness per SIGNED).
  - t+3: accumulator loads the product on the first term of a lag, otherwise adds it.
  - res_valid pulses at t+3 of the lag's final term, with res_data equal to the accumulator result.
- Arithmetic: ACC_W never overflows. Products are sign- or zero-extended per SIGNED.
- Max tracking:
  - First result of a run loads max_val/max_idx unconditionally.
  - Later results replace only if strictly greater (signed compare when SIGNED=1), so ties keep the earliest lag.
  - max_val/max_idx are valid once done=1 and stay stable until the next accepted start clears them.
- Timing: start accepted at cycle 0 → first address at cycle 1 → done=1 at cycle (terms+4).

Decomposition:
- Package xcorr_pkg: state enum (IDLE, RUN, DRAIN, DONE), pipeline depth constant (3), and the helper functions overlap_first(n) and overlap_last(n).
- Sub-module xcorr_mac: the registered multiply plus load/add accumulator, parametrised on DATA_W, ACC_W and SIGNED, with first/last tag pipelining.
- The top level holds the FSM, address counters and max tracker.

Test Plan:
- LEN=4, DATA_W=4, SIGNED=0, a=b=[1,2,3,4], lag_lo=0, lag_hi=6:
  - res_data 4,11,20,30,20,11,4 on res_idx 0..6.
  - 16 address cycles; done at cycle 20.
  - max_val=30, max_idx=3.
- Same data, lag_lo=2, lag_hi=4 → results 20,30,20 only; 10 address cycles; max 30 at 3; err=0.
- SIGNED=1, a=[-2,-2,-2,-2], b=[1,1,1,1], full window → res_data -2,-4,-6,-8,-6,-4,-2; max_val=-2, max_idx=0 (tie with lag 6 keeps the earliest).
- Tie with SIGNED=0, a=[1,0,0,0], b=[1,0,0,1] → r[0]=r[3]=1; max_idx=0.
- lag_lo=5, lag_hi=1 → err=1 and done next cycle, no res_valid. A following valid start clears err and runs normally.
- Reset asserted in RUN at cycle 5, then released → next cycle all outputs 0 and state IDLE, no further res_valid. A new start completes with the full correct sequence. A start pulse in DRAIN is ignored.

Source files
------------

// File: rtl/xcorr_pkg.sv
// Shared types and helpers for the cross-correlation engine.
// Holds the FSM state enum, pipeline depth and lag overlap bounds.
package xcorr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Cycles from address issue to accumulator update.
    localparam int PIPE_DEPTH = 3;

    // Smallest k with both a[n-k] and b[len-1-k] inside the signals.
    function automatic int overlap_first(int n, int len);
        return (n > len - 1) ? n - len + 1 : 0;
    endfunction

    // Largest such k.
    function automatic int overlap_last(int n, int len);
        return (n < len - 1) ? n : len - 1;
    endfunction

endpackage

// File: rtl/xcorr_mac.sv
// Registered multiply followed by a load/add accumulator.
// Ports: a/b samples with valid/first/last tags in; out_valid pulses with acc on a lag's last term.
module xcorr_mac #(
    parameter int DATA_W = 10,
    parameter int ACC_W  = 31,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    output logic [ACC_W-1:0]  acc
);

    localparam int PW = 2 * DATA_W;

    logic          sa;
    logic          sb;
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    logic [PW-1:0] prod;
    logic          p_valid;
    logic          p_first;
    logic          p_last;
    logic [ACC_W-1:0] pext;

    // Extending both operands to full product width makes one unsigned
    // multiply correct for either signedness.
    always_comb begin
        sa   = (SIGNED != 0) && a[DATA_W-1];
        sb   = (SIGNED != 0) && b[DATA_W-1];
        ax   = {{DATA_W{sa}}, a};
        bx   = {{DATA_W{sb}}, b};
        pext = {{(ACC_W-PW){(SIGNED != 0) && prod[PW-1]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prod      <= '0;
            p_valid   <= 1'b0;
            p_first   <= 1'b0;
            p_last    <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
        end else begin
            prod      <= ax * bx;
            p_valid   <= in_valid;
            p_first   <= in_first;
            p_last    <= in_last;
            out_valid <= p_valid && p_last;
            if (p_valid) begin
                acc <= p_first ? pext : acc + pext;
            end
        end
    end

endmodule

// File: rtl/xcorr_engine.sv
// Cross-correlation engine streaming r[n] over a lag window from two sample RAMs.
// Ports: start/lag_lo/lag_hi in, RAM a/b addr out and data in, res_* stream, busy/done/err, max_val/max_idx.
module xcorr_engine import xcorr_pkg::*; #(
    parameter int DATA_W = 10,
    parameter int LEN    = 2000,
    parameter int SIGNED = 0,
    parameter int ADDR_W = $clog2(LEN),
    parameter int IDX_W  = $clog2(2*LEN-1),
    parameter int ACC_W  = 2*DATA_W+$clog2(LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  lag_lo,
    input  logic [IDX_W-1:0]  lag_hi,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_idx,
    output logic [ACC_W-1:0]  res_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ACC_W-1:0]  max_val,
    output logic [IDX_W-1:0]  max_idx
);

    localparam int MAXLAG = 2 * LEN - 2;

    state_t           state;
    logic [IDX_W-1:0] n;
    logic [IDX_W-1:0] hi;
    logic [IDX_W-1:0] res_cnt;
    logic [ADDR_W-1:0] k;
    logic [1:0]       dcnt;
    logic             first_res;
    logic             s1_valid;
    logic             s1_first;
    logic             s1_last;

    logic [IDX_W-1:0]  hi_c;
    logic [IDX_W-1:0]  nn;
    logic [ADDR_W-1:0] nk;
    logic [ADDR_W-1:0] k0;
    logic              win_bad;
    logic              is_first;
    logic              is_last;
    logic              end_run;
    logic              gt;
    logic              take;
    logic              mac_valid;
    logic [ACC_W-1:0]  mac_acc;

    always_comb begin
        hi_c     = (int'(lag_hi) > MAXLAG) ? IDX_W'(MAXLAG) : lag_hi;
        win_bad  = lag_lo > hi_c;
        k0       = ADDR_W'(overlap_first(int'(lag_lo), LEN));
        is_first = int'(k) == overlap_first(int'(n), LEN);
        is_last  = int'(k) == overlap_last(int'(n), LEN);
        end_run  = is_last && (n == hi);
        // Next term: step k, or roll to the first term of the next lag.
        nn = n;
        nk = k + ADDR_W'(1);
        if (is_last) begin
            nn = n + IDX_W'(1);
            nk = ADDR_W'(overlap_first(int'(n) + 1, LEN));
        end
        if (SIGNED != 0) begin
            gt = $signed(mac_acc) > $signed(max_val);
        end else begin
            gt = mac_acc > max_val;
        end
        take = mac_valid && (first_res || gt);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            n         <= '0;
            k         <= '0;
            hi        <= '0;
            a_addr    <= '0;
            b_addr    <= '0;
            dcnt      <= '0;
            err       <= 1'b0;
            first_res <= 1'b0;
            res_cnt   <= '0;
            max_val   <= '0;
            max_idx   <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
        end else begin
            // Tags follow the address by one cycle to line up with RAM data.
            s1_valid <= (state == RUN);
            s1_first <= is_first;
            s1_last  <= is_last;
            if (mac_valid) begin
                res_cnt <= res_cnt + IDX_W'(1);
            end
            if (take) begin
                max_val   <= mac_acc;
                max_idx   <= res_cnt;
                first_res <= 1'b0;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        max_val   <= '0;
                        max_idx   <= '0;
                        first_res <= 1'b1;
                        res_cnt   <= lag_lo;
                        hi        <= hi_c;
                        err       <= win_bad;
                        if (win_bad) begin
                            state <= DONE;
                        end else begin
                            state  <= RUN;
                            n      <= lag_lo;
                            k      <= k0;
                            a_addr <= ADDR_W'(int'(lag_lo) - int'(k0));
                            b_addr <= ADDR_W'(LEN - 1 - int'(k0));
                        end
                    end
                end
                RUN: begin
                    if (end_run) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        n      <= nn;
                        k      <= nk;
                        a_addr <= ADDR_W'(int'(nn) - int'(nk));
                        b_addr <= ADDR_W'(LEN - 1 - int'(nk));
                    end
                end
                DRAIN: begin
                    if (dcnt == 2'(PIPE_DEPTH - 1)) begin
                        state <= DONE;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign res_valid = mac_valid;
    assign res_data  = mac_acc;
    assign res_idx   = res_cnt;

    xcorr_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a_data),
        .b         (b_data),
        .in_valid  (s1_valid),
        .in_first  (s1_first),
        .in_last   (s1_last),
        .out_valid (mac_valid),
        .acc       (mac_acc)
    );

endmodule
